// File: rtl/memory_arbiter_if.sv
// Shared handshake bundle between the fetch port, the data port, the memory
// port and the arbiter that sits between them.
//   master : arbiter view (grants/responses and memory request are outputs)
//   slave  : environment view (requesters and memory model)
interface memory_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [2:0]  d_funct3;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [2:0]  m_funct3;
   logic        m_ready;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   modport master (
      input  i_req, i_addr,
      output i_gnt, i_rvalid, i_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_funct3,
      output d_gnt, d_rvalid, d_rdata,
      output m_req, m_we, m_addr, m_wdata, m_funct3,
      input  m_ready, m_rvalid, m_rdata
   );

   modport slave (
      output i_req, i_addr,
      input  i_gnt, i_rvalid, i_rdata,
      output d_req, d_we, d_addr, d_wdata, d_funct3,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_req, m_we, m_addr, m_wdata, m_funct3,
      output m_ready, m_rvalid, m_rdata
   );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single memory port with at
// most one outstanding transaction and a wait-cycle timeout.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate winners when both ports
// request; otherwise data always beats fetch.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; grant a winner combinationally and latch it
// ISSUE | m_req driven from latched fields until m_ready
// WAIT  | request accepted; wait for m_rvalid or timeout
module memory_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   memory_arbiter_if.master bus,
   output logic             busy,
   output logic             bus_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic       OWN_I  = 1'b0;
   localparam logic       OWN_D  = 1'b1;
   localparam logic [4:0] TO_CNT = 5'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic        bus_err_q, bus_err_d;
   logic        m_we_q, m_we_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic [2:0]  m_funct3_q, m_funct3_d;

   logic        grant_i, grant_d;
   logic        done, abort;
   logic [31:0] rsp_data;

   // Winner selection, only meaningful in IDLE and suppressed during reset
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state_q == IDLE && !reset) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (bus.i_req && bus.d_req) begin
            grant_i = (last_owner_q == OWN_D);
            grant_d = (last_owner_q == OWN_I);
         end else begin
            grant_i = bus.i_req;
            grant_d = bus.d_req;
         end
`else
         grant_d = bus.d_req;
         grant_i = bus.i_req && !bus.d_req;
`endif
      end
   end

   // Next-state, field latching, completion and timeout decisions
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      bus_err_d    = bus_err_q;
      m_we_d       = m_we_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_funct3_d   = m_funct3_q;
      done         = 1'b0;
      abort        = 1'b0;
      rsp_data     = '0;
      unique case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d    = ISSUE;
               cnt_d      = '0;
               owner_d    = OWN_D;
               m_we_d     = bus.d_we;
               m_addr_d   = bus.d_addr;
               m_wdata_d  = bus.d_wdata;
               m_funct3_d = bus.d_funct3;
            end else if (grant_i) begin
               state_d    = ISSUE;
               cnt_d      = '0;
               owner_d    = OWN_I;
               m_we_d     = 1'b0;
               m_addr_d   = bus.i_addr;
               m_wdata_d  = '0;
               m_funct3_d = 3'b010;
            end
         end
         ISSUE: begin
            cnt_d = cnt_q + 5'd1;
            // a response seen before acceptance is not ours and is dropped
            if (cnt_q == TO_CNT) begin
               abort = 1'b1;
            end else if (bus.m_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 5'd1;
            // a response on the timeout cycle still counts as a completion
            if (bus.m_rvalid) begin
               done     = 1'b1;
               rsp_data = bus.m_rdata;
            end else if (cnt_q == TO_CNT) begin
               abort = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (done || abort) begin
         state_d      = IDLE;
         last_owner_d = owner_q;
      end
      if (abort) begin
         bus_err_d = 1'b1;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         owner_q      <= OWN_I;
         last_owner_q <= OWN_I;
         bus_err_q    <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_funct3_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         bus_err_q    <= bus_err_d;
         m_we_q       <= m_we_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_funct3_q   <= m_funct3_d;
      end
   end

   // Handshake outputs; reset masks every pulse so an aborted transfer stays silent
   always_comb begin
      bus.i_gnt    = grant_i;
      bus.d_gnt    = grant_d;
      bus.i_rvalid = !reset && (done || abort) && (owner_q == OWN_I);
      bus.d_rvalid = !reset && (done || abort) && (owner_q == OWN_D);
      bus.i_rdata  = (owner_q == OWN_I) ? rsp_data : '0;
      bus.d_rdata  = (owner_q == OWN_D) ? rsp_data : '0;
      bus.m_req    = !reset && (state_q == ISSUE);
      bus.m_we     = m_we_q;
      bus.m_addr   = m_addr_q;
      bus.m_wdata  = m_wdata_q;
      bus.m_funct3 = m_funct3_q;
      busy         = !reset && (state_q != IDLE);
      bus_err      = bus_err_q;
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter: a transaction-level model tracks the
// single outstanding request by its age in cycles since grant and predicts
// grants, memory requests, responses, timeouts and the sticky error flag.
module tb_memory_arbiter;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic busy, bus_err;

   memory_arbiter_if bus_if ();

   memory_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus_if.master),
      .busy    (busy),
      .bus_err (bus_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // stimulus knobs (percent probabilities)
   int unsigned p_ireq, p_dreq, p_rdy, p_rv, p_rst;
   int          rv_age;
   bit          force_reset;

   // requester state
   bit i_pend, d_pend;

   // reference model of the single outstanding transaction
   bit          mb_busy, mb_acc, mb_own, mb_last, mb_err;
   int          mb_age;
   bit          mb_we;
   logic [31:0] mb_addr, mb_wdata;
   logic [2:0]  mb_f3;

   task automatic step();
      bit          eig, edg, eir, edr, emreq, ebusy, ab, dn;
      logic [31:0] erd;
      @(posedge clk);
      #1;
      reset = force_reset || (mb_busy && ($urandom_range(99) < p_rst));
      if (!i_pend && ($urandom_range(99) < p_ireq)) begin
         i_pend         = 1'b1;
         bus_if.i_addr  = $urandom;
      end
      if (!d_pend && ($urandom_range(99) < p_dreq)) begin
         d_pend          = 1'b1;
         bus_if.d_we     = 1'($urandom_range(1));
         bus_if.d_addr   = $urandom;
         bus_if.d_wdata  = $urandom;
         bus_if.d_funct3 = 3'($urandom_range(7));
      end
      bus_if.i_req    = i_pend;
      bus_if.d_req    = d_pend;
      bus_if.m_ready  = ($urandom_range(99) < p_rdy);
      bus_if.m_rvalid = ($urandom_range(99) < p_rv) || (mb_busy && mb_age == rv_age);
      bus_if.m_rdata  = $urandom;
      #3;
      eig = 0; edg = 0; eir = 0; edr = 0; emreq = 0; ebusy = 0; ab = 0; dn = 0; erd = '0;
      if (!reset) begin
         if (!mb_busy) begin
            eig = i_pend;
            edg = d_pend;
            if (eig && edg) begin
`ifdef ARB_ROUND_ROBIN_EN
               eig = mb_last;
               edg = !mb_last;
`else
               eig = 1'b0;
`endif
            end
         end else begin
            ebusy = 1'b1;
            emreq = !mb_acc;
            if (mb_acc && bus_if.m_rvalid) begin
               dn  = 1'b1;
               erd = bus_if.m_rdata;
            end else if (mb_age == TO + 1) begin
               ab = 1'b1;
            end
            eir = (dn || ab) && !mb_own;
            edr = (dn || ab) && mb_own;
         end
      end
      check_val("i_gnt", bus_if.i_gnt, eig);
      check_val("d_gnt", bus_if.d_gnt, edg);
      check_val("i_rvalid", bus_if.i_rvalid, eir);
      check_val("d_rvalid", bus_if.d_rvalid, edr);
      check_val("m_req", bus_if.m_req, emreq);
      check_val("busy", busy, ebusy);
      check_val("bus_err", bus_err, mb_err);
      if (eir) check_val("i_rdata", bus_if.i_rdata, erd);
      if (edr) check_val("d_rdata", bus_if.d_rdata, erd);
      if (emreq) begin
         check_val("m_addr", bus_if.m_addr, mb_addr);
         check_val("m_we", bus_if.m_we, mb_we);
         check_val("m_wdata", bus_if.m_wdata, mb_wdata);
         check_val("m_funct3", bus_if.m_funct3, mb_f3);
      end
      // advance the model to what the coming clock edge produces
      if (reset) begin
         mb_busy = 0; mb_last = 0; mb_err = 0;
      end else if (!mb_busy) begin
         if (edg) begin
            mb_we = bus_if.d_we; mb_addr = bus_if.d_addr;
            mb_wdata = bus_if.d_wdata; mb_f3 = bus_if.d_funct3;
            d_pend = 1'b0;
         end else if (eig) begin
            mb_we = 1'b0; mb_addr = bus_if.i_addr; mb_wdata = '0; mb_f3 = 3'b010;
            i_pend = 1'b0;
         end
         if (eig || edg) begin
            mb_busy = 1; mb_acc = 0; mb_age = 1; mb_own = edg;
         end
      end else if (dn || ab) begin
         mb_busy = 0;
         mb_last = mb_own;
         if (ab) mb_err = 1;
      end else begin
         if (!mb_acc && bus_if.m_ready) mb_acc = 1;
         mb_age++;
      end
   endtask

   task automatic phase(input int unsigned pi, input int unsigned pd, input int unsigned pr,
                        input int unsigned pv, input int unsigned ps, input int n);
      p_ireq = pi; p_dreq = pd; p_rdy = pr; p_rv = pv; p_rst = ps;
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      bus_if.i_req = 0; bus_if.i_addr = '0;
      bus_if.d_req = 0; bus_if.d_we = 0; bus_if.d_addr = '0;
      bus_if.d_wdata = '0; bus_if.d_funct3 = '0;
      bus_if.m_ready = 0; bus_if.m_rvalid = 0; bus_if.m_rdata = '0;
      i_pend = 0; d_pend = 0;
      mb_busy = 0; mb_acc = 0; mb_own = 0; mb_last = 0; mb_err = 0; mb_age = 0;
      mb_we = 0; mb_addr = '0; mb_wdata = '0; mb_f3 = '0;
      rv_age = -1;

      // reset with traffic pending: nothing may be granted or issued
      force_reset = 1;
      phase(100, 100, 100, 100, 0, 3);
      force_reset = 0;
      check_val("rst_m_addr", bus_if.m_addr, 32'h0);
      check_val("rst_m_wdata", bus_if.m_wdata, 32'h0);
      check_val("rst_m_funct3", {29'd0, bus_if.m_funct3}, 32'h0);

      phase(0, 0, 100, 100, 0, 1);       // drop pending traffic
      phase(0, 0, 100, 100, 0, 2);
      i_pend = 0; d_pend = 0;
      phase(100, 0, 100, 100, 0, 30);    // back-to-back fetches
      phase(0, 100, 100, 100, 0, 30);    // back-to-back data
      phase(100, 100, 100, 100, 0, 40);  // both always requesting
      rv_age = TO + 1;
      phase(60, 60, 100, 0, 0, 60);      // response on the timeout cycle wins
      rv_age = -1;
      phase(60, 60, 0, 30, 0, 50);       // never accepted: abort in ISSUE
      phase(60, 60, 100, 0, 0, 45);      // accepted, no response: abort in WAIT
      phase(60, 60, 100, 100, 0, 20);    // service continues after abort
      phase(50, 50, 40, 40, 0, 150);     // stalls and delayed responses
      phase(50, 50, 50, 50, 10, 200);    // resets mid-transaction
      phase(70, 70, 30, 30, 0, 150);
      phase(0, 0, 50, 50, 0, 30);        // drain

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
